// File: rtl/alu.sv
// Single-cycle 32-bit integer ALU with registered result and zero flag.
// The zero flag is derived from the next result so both registers always agree.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ALU_control,
    input  logic [31:0] arg1,
    input  logic [31:0] arg2,
    output logic        Zero,
    output logic [31:0] ALU_result
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic [31:0] result_d;
    logic [31:0] result_q;
    logic        zero_d;
    logic        zero_q;

    // Operation decode; SLT uses a true signed compare so it stays correct on overflow.
    always_comb begin
        result_d = 32'h0000_0000;
        case (ALU_control)
            OP_AND:  result_d = arg1 & arg2;
            OP_OR:   result_d = arg1 | arg2;
            OP_ADD:  result_d = arg1 + arg2;
            OP_SUB:  result_d = arg1 - arg2;
            OP_SLT:  result_d = ($signed(arg1) < $signed(arg2)) ? 32'd1 : 32'd0;
            OP_NOR:  result_d = ~(arg1 | arg2);
            default: result_d = 32'h0000_0000;
        endcase
        zero_d = (result_d == 32'h0000_0000);
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= 32'h0000_0000;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign ALU_result = result_q;
    assign Zero       = zero_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the alu; inputs change on the falling edge,
// outputs are sampled 1 time unit after the rising edge.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [3:0]  ALU_control;
    logic [31:0] arg1;
    logic [31:0] arg2;
    logic        Zero;
    logic [31:0] ALU_result;

    int n_checks = 0;
    int n_fail   = 0;

    alu dut (
        .clk        (clk),
        .rst        (rst),
        .ALU_control(ALU_control),
        .arg1       (arg1),
        .arg2       (arg2),
        .Zero       (Zero),
        .ALU_result (ALU_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // Drive one operation on the falling edge, then step past the next rising edge.
    task automatic drive(input logic r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        rst         = r;
        ALU_control = op;
        arg1        = a;
        arg2        = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ALU_control = 4'b0010; arg1 = 32'h1234_5678; arg2 = 32'h0000_0001;
        @(posedge clk);
        #1;
        n_checks++;
        if (ALU_result !== 32'h0000_0000 || Zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: result=%h zero=%b expected 00000000/1", ALU_result, Zero);
        end
        drive(1'b0, 4'b0000, 32'h0000_0001, 32'h0000_0000);
        n_checks++;
        if (ALU_result !== 32'h0000_0000 || Zero !== 1'b1) begin
            n_fail++;
            $display("FAIL and_1_0: result=%h zero=%b expected 00000000/1", ALU_result, Zero);
        end
    endtask

    task automatic test_logic();
        logic [3:0]  ops [3] = '{4'b0000, 4'b0001, 4'b1100};
        logic [31:0] exp [3] = '{32'h080010B2, 32'h4E0F93FF, 32'hB1F06C00};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, ops[i], 32'h4E0F92BE, 32'h080011F3);
            n_checks++;
            if (ALU_result !== exp[i] || Zero !== 1'b0) begin
                n_fail++;
                $display("FAIL logic_op%b: result=%h zero=%b expected %h/0", ops[i], ALU_result, Zero, exp[i]);
            end
        end
    endtask

    // Back-to-back operations: each result follows its input change by one edge.
    task automatic test_arith();
        logic [3:0]  ops [3] = '{4'b0001, 4'b0110, 4'b0010};
        logic [31:0] exp [3] = '{32'h1274FEFD, 32'h11C0DE73, 32'h12A91F45};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, ops[i], 32'h1234FEDC, 32'h00742069);
            n_checks++;
            if (ALU_result !== exp[i] || Zero !== 1'b0) begin
                n_fail++;
                $display("FAIL arith_op%b: result=%h zero=%b expected %h/0", ops[i], ALU_result, Zero, exp[i]);
            end
        end
    endtask

    task automatic test_zero_wrap();
        logic [3:0]  ops [3] = '{4'b0110, 4'b0010, 4'b0110};
        logic [31:0] as  [3] = '{32'h11110000, 32'hFFFFFFFF, 32'h00000000};
        logic [31:0] bs  [3] = '{32'h11110000, 32'h00000001, 32'h00000001};
        logic [31:0] exp [3] = '{32'h00000000, 32'h00000000, 32'hFFFFFFFF};
        logic        ez  [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, ops[i], as[i], bs[i]);
            n_checks++;
            if (ALU_result !== exp[i] || Zero !== ez[i]) begin
                n_fail++;
                $display("FAIL zero_wrap%0d: result=%h zero=%b expected %h/%b", i, ALU_result, Zero, exp[i], ez[i]);
            end
        end
    endtask

    task automatic test_slt();
        logic [31:0] as  [4] = '{32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'hDEADBEEF};
        logic [31:0] bs  [4] = '{32'h00000001, 32'h80000000, 32'h80000000, 32'hDEADBEEF};
        logic [31:0] exp [4] = '{32'd1, 32'd0, 32'd0, 32'd0};
        logic        ez  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'b0111, as[i], bs[i]);
            n_checks++;
            if (ALU_result !== exp[i] || Zero !== ez[i]) begin
                n_fail++;
                $display("FAIL slt%0d: result=%h zero=%b expected %h/%b", i, ALU_result, Zero, exp[i], ez[i]);
            end
        end
    endtask

    task automatic test_undef_hold();
        drive(1'b0, 4'b1111, 32'hA5A5A5A5, 32'h5A5A5A5A);
        n_checks++;
        if (ALU_result !== 32'h0000_0000 || Zero !== 1'b1) begin
            n_fail++;
            $display("FAIL undef_op: result=%h zero=%b expected 00000000/1", ALU_result, Zero);
        end
        // Change inputs mid-cycle; outputs must hold until the next edge.
        ALU_control = 4'b0010; arg1 = 32'h0000_0005; arg2 = 32'h0000_0006;
        @(negedge clk);
        #2;
        n_checks++;
        if (ALU_result !== 32'h0000_0000 || Zero !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_between_edges: result=%h zero=%b expected 00000000/1", ALU_result, Zero);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (ALU_result !== 32'h0000_000B || Zero !== 1'b0) begin
            n_fail++;
            $display("FAIL capture_after_hold: result=%h zero=%b expected 0000000b/0", ALU_result, Zero);
        end
    endtask

    task automatic test_midstream_reset();
        drive(1'b1, 4'b0001, 32'hFFFF_0000, 32'h0000_FFFF);
        n_checks++;
        if (ALU_result !== 32'h0000_0000 || Zero !== 1'b1) begin
            n_fail++;
            $display("FAIL midstream_reset: result=%h zero=%b expected 00000000/1", ALU_result, Zero);
        end
        drive(1'b0, 4'b0001, 32'hFFFF_0000, 32'h0000_FFFF);
        n_checks++;
        if (ALU_result !== 32'hFFFF_FFFF || Zero !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_release: result=%h zero=%b expected ffffffff/0", ALU_result, Zero);
        end
    endtask

    initial begin
        test_reset();
        test_logic();
        test_arith();
        test_zero_wrap();
        test_slt();
        test_undef_hold();
        test_midstream_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
